pll_rst_seq: RTL



---
 rtl/pll_rst_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// Power-up reset sequencer: PLL reset and lock qualification, then the PHY hardware reset,
// then release of the system reset. A lost lock reruns the sequence from WAIT_LOCK.
module pll_rst_seq #(
  parameter int PLL_RST_CYC     = 16,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int LOCK_STABLE_CYC = 1000,
  parameter int PHY_RST_CYC     = 500000,
  parameter int PHY_WAIT_CYC    = 250000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       eth_rst_n,
  output logic       rst_n_out,
  output logic       init_done,
  output logic [3:0] retry_cnt
);

  localparam int MAX_A   = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_STABLE_CYC > PHY_RST_CYC) ? LOCK_STABLE_CYC : PHY_RST_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > PHY_WAIT_CYC) ? MAX_C : PHY_WAIT_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PLL_RST_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST   = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] PHY_RST_LAST  = CW'(PHY_RST_CYC - 1);
  localparam logic [CW-1:0] PHY_WAIT_LAST = CW'(PHY_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    PLL_RST, WAIT_LOCK, LOCK_STABLE, PHY_RST, PHY_WAIT, RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            lock_meta_q, lock_meta_d;
  logic            lock_s_q, lock_s_d;
  logic            pll_reset_q, pll_reset_d;
  logic            eth_rst_n_q, eth_rst_n_d;
  logic            rst_n_out_q, rst_n_out_d;
  logic            init_done_q, init_done_d;

  always_comb begin
    lock_meta_d = pll_locked;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q + CW'(1);

    // Lock loss is tested before any terminal count so it always wins.
    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = LOCK_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end
      end
      LOCK_STABLE: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = PHY_RST;
      end
      PHY_RST: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (cnt_q == PHY_RST_LAST) state_d = PHY_WAIT;
      end
      PHY_WAIT: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (cnt_q == PHY_WAIT_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
      end
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs decode the next state so they register in step with the state itself.
    pll_reset_d = (state_d == PLL_RST);
    eth_rst_n_d = (state_d == PHY_WAIT) || (state_d == RUN);
    rst_n_out_d = (state_d == RUN);
    init_done_d = (state_d == RUN);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      eth_rst_n_q <= 1'b0;
      rst_n_out_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      eth_rst_n_q <= eth_rst_n_d;
      rst_n_out_q <= rst_n_out_d;
      init_done_q <= init_done_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign eth_rst_n = eth_rst_n_q;
  assign rst_n_out = rst_n_out_q;
  assign init_done = init_done_q;
  assign retry_cnt = retry_q;

endmodule
